// File: rtl/corr_sweep_peak.sv
// ---------------------------------------------------------------------------
// corr_sweep_peak
//
// Moves the correlation scorer's window across every candidate position of
// the frame on a raster grid with pitch STEP, and keeps the highest score
// seen together with the window start where it occurred. A one-cycle oDone
// pulse reports the end of a sweep.
//
// Ports
//   iCLK        system clock
//   iRST        synchronous, active-high reset
//   iStart      single-cycle pulse; starts a sweep, accepted only in IDLE
//   iFinished   scorer finished pulse, one cycle wide
//   iScore      scorer result; valid from the cycle after iFinished
//   oXstart     window X start, driven to the scorer
//   oYstart     window Y start, driven to the scorer
//   oBusy       high from the accepted iStart until oDone
//   oDone       one-cycle pulse when the sweep completes
//   oBestX      X start of the best window
//   oBestY      Y start of the best window
//   oBestScore  best score found
//   oState      debug view of the sweep state machine (IDLE encodes as 0)
//
// Handshake: there is no valid/ready pair. iStart is a request that is taken
// only when the FSM is in IDLE and dropped otherwise; iFinished is a strobe
// that the FSM consumes only in SYNC and RUN and ignores in every other
// state. iScore is sampled exactly once, in the CAPTURE cycle that follows
// a consumed iFinished in RUN.
// ---------------------------------------------------------------------------
module corr_sweep_peak #(
  parameter int FRAME_H = 640,
  parameter int FRAME_V = 480,
  parameter int TPL_H   = 64,
  parameter int TPL_V   = 64,
  parameter int STEP    = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iStart,
  input  logic        iFinished,
  input  logic [31:0] iScore,
  output logic [12:0] oXstart,
  output logic [12:0] oYstart,
  output logic        oBusy,
  output logic        oDone,
  output logic [12:0] oBestX,
  output logic [12:0] oBestY,
  output logic [31:0] oBestScore,
  output logic [2:0]  oState
);

  localparam int X_MAX = FRAME_H - TPL_H;
  localparam int Y_MAX = FRAME_V - TPL_V;

  localparam logic [13:0] X_MAX_W = 14'(X_MAX);
  localparam logic [13:0] Y_MAX_W = 14'(Y_MAX);
  localparam logic [13:0] STEP_W  = 14'(STEP);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    RUN     = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [12:0] x_q, x_d;
  logic [12:0] y_q, y_d;
  logic [12:0] pend_x_q, pend_x_d;
  logic [12:0] pend_y_q, pend_y_d;
  logic        pend_last_q, pend_last_d;
  logic        found_q, found_d;
  logic [12:0] best_x_q, best_x_d;
  logic [12:0] best_y_q, best_y_d;
  logic [31:0] best_score_q, best_score_d;

  // Next raster position. Sums are one bit wider than the coordinates so a
  // step past the edge can never wrap back into range.
  logic [13:0] nx;
  logic [13:0] ny;
  logic        x_wrap;
  logic        at_last;

  always_comb begin
    nx      = {1'b0, x_q} + STEP_W;
    ny      = {1'b0, y_q} + STEP_W;
    x_wrap  = (nx > X_MAX_W);
    at_last = x_wrap && (ny > Y_MAX_W);
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    pend_x_d     = pend_x_q;
    pend_y_d     = pend_y_q;
    pend_last_d  = pend_last_q;
    found_d      = found_q;
    best_x_d     = best_x_q;
    best_y_d     = best_y_q;
    best_score_d = best_score_q;

    unique case (state_q)
      IDLE: begin
        x_d = '0;
        y_d = '0;
        if (iStart) begin
          found_d      = 1'b0;
          best_x_d     = '0;
          best_y_d     = '0;
          best_score_d = '0;
          state_d      = SYNC;
        end
      end

      // The scorer free-runs; the window in flight when the sweep starts
      // was not set up by us, so its result is thrown away. The scorer
      // restarts on this edge and picks up (0,0).
      SYNC: begin
        if (iFinished) begin
          state_d = RUN;
        end
      end

      // The scorer samples the start inputs from the cycle after its
      // finished pulse, so the coordinates must move on this same edge.
      RUN: begin
        if (iFinished) begin
          pend_x_d    = x_q;
          pend_y_d    = y_q;
          pend_last_d = at_last;
          if (!at_last) begin
            if (x_wrap) begin
              x_d = '0;
              y_d = ny[12:0];
            end else begin
              x_d = nx[12:0];
            end
          end
          state_d = CAPTURE;
        end
      end

      // Strict greater-than keeps the earliest raster position on ties;
      // the first capture of a sweep loads unconditionally.
      CAPTURE: begin
        if (!found_q || (iScore > best_score_q)) begin
          best_score_d = iScore;
          best_x_d     = pend_x_q;
          best_y_d     = pend_y_q;
          found_d      = 1'b1;
        end
        state_d = pend_last_q ? DONE : RUN;
      end

      DONE: begin
        x_d     = '0;
        y_d     = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      pend_x_q     <= '0;
      pend_y_q     <= '0;
      pend_last_q  <= 1'b0;
      found_q      <= 1'b0;
      best_x_q     <= '0;
      best_y_q     <= '0;
      best_score_q <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      pend_x_q     <= pend_x_d;
      pend_y_q     <= pend_y_d;
      pend_last_q  <= pend_last_d;
      found_q      <= found_d;
      best_x_q     <= best_x_d;
      best_y_q     <= best_y_d;
      best_score_q <= best_score_d;
    end
  end

  assign oXstart    = x_q;
  assign oYstart    = y_q;
  assign oBusy      = (state_q != IDLE);
  assign oDone      = (state_q == DONE);
  assign oBestX     = best_x_q;
  assign oBestY     = best_y_q;
  assign oBestScore = best_score_q;
  assign oState     = state_q;

endmodule

// File: tb/tb_corr_sweep_peak.sv
// ---------------------------------------------------------------------------
// tb_corr_sweep_peak
//
// Two instances: an 8x8 frame / 4x4 template / step 2 sweep (9 positions)
// and a degenerate 4x4 / 4x4 frame with a single position. Each instance is
// surrounded by a free-running scorer model that reads the start coordinates
// the cycle after each finished pulse and returns a score looked up from a
// per-position table. Windows started while the DUT was idle return
// 32'hFFFF_FFFF so a result that should be discarded would stand out.
// ---------------------------------------------------------------------------
module tb_corr_sweep_peak;

  localparam int FHA = 8, FVA = 8, THA = 4, TVA = 4, STA = 2;
  localparam int XMA = FHA - THA, YMA = FVA - TVA;
  localparam int NXA = XMA / STA + 1;
  localparam int WIN_A = 20;
  localparam int WIN_B = 12;
  localparam logic [31:0] BOGUS = 32'hFFFF_FFFF;

  // clock / reset
  logic clk = 1'b0;
  always #10 clk = ~clk;
  logic rst;

  // DUT A
  logic        start_a, fin_a;
  logic [31:0] score_a;
  logic [12:0] xa, ya, bxa, bya;
  logic        busy_a, done_a;
  logic [31:0] bsa;
  logic [2:0]  st_a;

  // DUT B
  logic        start_b, fin_b;
  logic [31:0] score_b;
  logic [12:0] xb, yb, bxb, byb;
  logic        busy_b, done_b;
  logic [31:0] bsb;
  logic [2:0]  st_b;

  corr_sweep_peak #(.FRAME_H(FHA), .FRAME_V(FVA), .TPL_H(THA), .TPL_V(TVA), .STEP(STA)) dut_a (
    .iCLK(clk), .iRST(rst), .iStart(start_a), .iFinished(fin_a), .iScore(score_a),
    .oXstart(xa), .oYstart(ya), .oBusy(busy_a), .oDone(done_a),
    .oBestX(bxa), .oBestY(bya), .oBestScore(bsa), .oState(st_a)
  );

  corr_sweep_peak #(.FRAME_H(4), .FRAME_V(4), .TPL_H(4), .TPL_V(4), .STEP(4)) dut_b (
    .iCLK(clk), .iRST(rst), .iStart(start_b), .iFinished(fin_b), .iScore(score_b),
    .oXstart(xb), .oYstart(yb), .oBusy(busy_b), .oDone(done_b),
    .oBestX(bxb), .oBestY(byb), .oBestScore(bsb), .oState(st_b)
  );

  // scoreboard
  int total = 0;
  int bad   = 0;
  logic [25:0] exp_q[$];
  logic [25:0] seen_a[$];
  logic [25:0] seen_b[$];
  logic [31:0] score_tab[0:NXA*NXA-1];
  int done_cnt_a = 0;
  int done_cnt_b = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] score_of(input int x, input int y, input bit started_busy);
    if (!started_busy) return BOGUS;
    return score_tab[(y / STA) * NXA + x / STA];
  endfunction

  // scorer model A: fixed-length windows, start coords read after restart
  int sc_a = 0, wxa = 0, wya = 0;
  bit wba = 1'b0;
  initial begin
    fin_a = 1'b0;
    score_a = '0;
    forever begin
      @(negedge clk);
      if (done_a) done_cnt_a++;
      if (sc_a == WIN_A - 1) begin
        fin_a = 1'b1;
        score_a = score_of(wxa, wya, wba);
        sc_a = 0;
        if (busy_a) seen_a.push_back({xa, ya});
      end else begin
        fin_a = 1'b0;
        if (sc_a == 0) begin
          wxa = int'(xa);
          wya = int'(ya);
          wba = busy_a;
        end
        sc_a++;
      end
    end
  end

  // scorer model B: constant 77 for windows it was asked to score
  int sc_b = 0;
  bit wbb = 1'b0;
  initial begin
    fin_b = 1'b0;
    score_b = '0;
    forever begin
      @(negedge clk);
      if (done_b) done_cnt_b++;
      if (sc_b == WIN_B - 1) begin
        fin_b = 1'b1;
        score_b = wbb ? 32'd77 : BOGUS;
        sc_b = 0;
        if (busy_b) seen_b.push_back({xb, yb});
      end else begin
        fin_b = 1'b0;
        if (sc_b == 0) wbb = busy_b;
        sc_b++;
      end
    end
  end

  // reference: raster order list and best-of with first-load / strict-greater
  task automatic build_expect(output int bx, output int by, output logic [31:0] bs);
    bit have;
    have = 1'b0;
    bx = 0; by = 0; bs = '0;
    exp_q.delete();
    for (int y = 0; y <= YMA; y += STA) begin
      for (int x = 0; x <= XMA; x += STA) begin
        exp_q.push_back({13'(x), 13'(y)});
        if (!have || score_tab[(y / STA) * NXA + x / STA] > bs) begin
          bs = score_tab[(y / STA) * NXA + x / STA];
          bx = x;
          by = y;
          have = 1'b1;
        end
      end
    end
  endtask

  task automatic fill_table(input int mode);
    for (int i = 0; i < NXA * NXA; i++) begin
      case (mode)
        0: score_tab[i] = $urandom_range(0, 7);
        1: score_tab[i] = $urandom;
        2: score_tab[i] = 32'd100;
        3: score_tab[i] = 32'd10;
        default: score_tab[i] = 32'd0;
      endcase
    end
    if (mode == 2) score_tab[(2 / STA) * NXA + 4 / STA] = 32'd500;
    if (mode == 3) begin
      score_tab[(0 / STA) * NXA + 2 / STA] = 32'd300;
      score_tab[(4 / STA) * NXA + 0 / STA] = 32'd300;
    end
  endtask

  // driver tasks
  task automatic pulse_start_a();
    for (int i = 0; i < 2 * WIN_A && sc_a != WIN_A / 2; i++) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_a) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_seen_a(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (seen_a.size() >= n) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic full_sweep_a(input string name);
    int bx, by, d0;
    logic [31:0] bs;
    bit ok;
    build_expect(bx, by, bs);
    seen_a.delete();
    d0 = done_cnt_a;
    pulse_start_a();
    check({name, "_busy_after_start"}, 32'(busy_a), 32'd1);
    wait_done_a(ok);
    check({name, "_done_seen"}, 32'(ok), 32'd1);
    @(negedge clk);
    check({name, "_busy_after_done"}, 32'(busy_a), 32'd0);
    check({name, "_done_one_cycle"}, 32'(done_a), 32'd0);
    check({name, "_finishes"}, 32'(seen_a.size()), 32'(exp_q.size() + 1));
    if (seen_a.size() == exp_q.size() + 1) begin
      check({name, "_sync_pos"}, 32'(seen_a[0]), 32'd0);
      foreach (exp_q[i]) check($sformatf("%s_pos%0d", name, i), 32'(seen_a[i + 1]), 32'(exp_q[i]));
    end
    check({name, "_best_x"}, 32'(bxa), 32'(bx));
    check({name, "_best_y"}, 32'(bya), 32'(by));
    check({name, "_best_score"}, bsa, bs);
    repeat (WIN_A * 2) @(negedge clk);
    check({name, "_done_count"}, 32'(done_cnt_a - d0), 32'd1);
    check({name, "_best_hold"}, bsa, bs);
  endtask

  initial begin
    int bx, by, d0;
    logic [31:0] bs;
    bit ok;
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_x", 32'(xa), 32'd0);
    check("rst_y", 32'(ya), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_best", {6'd0, bxa, bya} | bsa, 32'd0);
    check("rst_state", 32'(st_a), 32'd0);

    fill_table(0); full_sweep_a("rand0");
    fill_table(1); full_sweep_a("rand1");
    fill_table(2); full_sweep_a("peak");
    check("peak_x_const", 32'(bxa), 32'd4);
    check("peak_y_const", 32'(bya), 32'd2);
    check("peak_s_const", bsa, 32'd500);
    fill_table(3); full_sweep_a("tie");
    check("tie_x_const", 32'(bxa), 32'd2);
    check("tie_y_const", 32'(bya), 32'd0);
    fill_table(4); full_sweep_a("zero");
    check("zero_s_const", bsa, 32'd0);

    // extra iStart mid-sweep, then reset mid-sweep
    fill_table(0);
    build_expect(bx, by, bs);
    seen_a.delete();
    d0 = done_cnt_a;
    pulse_start_a();
    wait_seen_a(5, ok);
    check("abort_reach_cap4", 32'(ok), 32'd1);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_seen_a(6, ok);
    check("abort_reach_cap5", 32'(ok), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", 32'(st_a), 32'd0);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_xy", 32'({xa, ya}), 32'd0);
    check("abort_best", {6'd0, bxa, bya} | bsa, 32'd0);
    if (seen_a.size() >= 6)
      for (int i = 0; i < 5; i++) check($sformatf("abort_pos%0d", i), 32'(seen_a[i + 1]), 32'(exp_q[i]));
    repeat (WIN_A * 12) @(negedge clk);
    check("abort_no_done", 32'(done_cnt_a - d0), 32'd0);
    check("abort_idle_stays", 32'(busy_a), 32'd0);

    // iStart together with reset: reset wins
    rst = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start_a = 1'b0;
    check("rst_start_state", 32'(st_a), 32'd0);
    check("rst_start_busy", 32'(busy_a), 32'd0);

    fill_table(0); full_sweep_a("fresh");

    // degenerate single-position sweep
    seen_b.delete();
    d0 = done_cnt_b;
    for (int i = 0; i < 2 * WIN_B && sc_b != WIN_B / 2; i++) @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (done_b) ok = 1'b1;
    end
    check("deg_done_seen", 32'(ok), 32'd1);
    @(negedge clk);
    check("deg_busy_after", 32'(busy_b), 32'd0);
    check("deg_finishes", 32'(seen_b.size()), 32'd2);
    if (seen_b.size() == 2) check("deg_pos", 32'(seen_b[1]), 32'd0);
    check("deg_best_x", 32'(bxb), 32'd0);
    check("deg_best_y", 32'(byb), 32'd0);
    check("deg_best_score", bsb, 32'd77);
    repeat (WIN_B * 3) @(negedge clk);
    check("deg_done_count", 32'(done_cnt_b - d0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/corr_sweep_peak.md
Name: corr_sweep_peak

Overview:
- Drives the window start coordinates of the correlation scorer across every candidate position of the frame, on a raster grid with a configurable step.
- Consumes the scorer's finished pulse and score. Tracks the maximum score and where it occurred.
- Sits directly downstream of and around the correlation scorer: it generates the scorer's start-coordinate inputs and receives its score outputs.
- Reports the best match position to the tracking/overlay logic with a one-cycle done pulse.

Parameters:
- FRAME_H, 640: frame width in pixels.
- FRAME_V, 480: frame height in pixels.
- TPL_H, 64: template (search window) width in pixels.
- TPL_V, 64: template (search window) height in pixels.
- STEP, 4: grid step in pixels, same in X and Y, ≥1.
- Derived: X_MAX = FRAME_H-TPL_H; Y_MAX = FRAME_V-TPL_V.

Ports:
- iCLK  in  1  system clock, 50 MHz.
- iRST  in  1  reset; synchronous, active-high.
- iStart  in  1  single-cycle pulse; begins a sweep. Ignored unless idle.
- iFinished  in  1  scorer finished pulse, one cycle wide.
- iScore  in  32  scorer score; valid from the cycle after iFinished.
- oXstart  out  13  window X start, to the scorer.
- oYstart  out  13  window Y start, to the scorer.
- oBusy  out  1  high from the accepted iStart until oDone.
- oDone  out  1  one-cycle pulse; sweep complete.
- oBestX  out  13  X start of the best window.
- oBestY  out  13  Y start of the best window.
- oBestScore  out  32  best score found.

Behaviour:
- One clock: iCLK. Reset iRST is synchronous and active-high.
- Reset values: oXstart=0, oYstart=0, oBusy=0, oDone=0, oBestX=0, oBestY=0, oBestScore=0, state=IDLE.
- Reset asserted mid-sweep aborts the sweep. No oDone is produced and all outputs return to their reset values the next cycle.

State machine:
- IDLE:
  - oBusy=0. oXstart/oYstart held at 0.
  - On iStart: clear the first-capture flag, set oBusy=1, go to SYNC.
- SYNC:
  - The scorer free-runs, so its in-flight result is discarded.
  - On the first iFinished, go to RUN. The scorer restarts on that edge with start (0,0).
- RUN:
  - Wait for iFinished.
  - On iFinished, on that same edge:
    - latch the completed position (oXstart, oYstart) into pend_x/pend_y;
    - advance oXstart/oYstart to the next grid position, or hold them if the completed position was the last;
    - go to CAPTURE.
  - Advancing on this edge is required: the scorer reads the start inputs combinationally from the next cycle on.
- CAPTURE (exactly 1 cycle):
  - Sample iScore.
  - If the first-capture flag is clear, or iScore > oBestScore (unsigned, strict): load oBestScore=iScore, oBestX=pend_x, oBestY=pend_y, and set the flag.
  - Ties keep the earliest position in raster order.
  - Next state: DONE if the captured position was the last, else RUN.
- DONE:
  - oDone=1 for one cycle, oBusy drops to 0 the next cycle, go to IDLE.
  - oBest* hold until the next accepted iStart.

Grid advance:
- nx = x+STEP.
- If nx > X_MAX: x=0 and ny = y+STEP.
- If ny > Y_MAX: the current position is the last.
- Positions per axis = floor(X_MAX/STEP)+1 (likewise Y).
- Compare using 14-bit sums so the increment cannot wrap at 13 bits.
- Degenerate case: X_MAX=0 and Y_MAX=0 gives a single position (0,0).

Boundary conditions:
- iStart while busy (any non-IDLE state) is ignored; the current sweep is unaffected.
- iFinished during CAPTURE or DONE cannot occur in legal operation (a window takes ≥TPL_H·TPL_V cycles). If it does occur it is ignored.
- iStart and iRST in the same cycle: reset wins.
- Captures per sweep = position count exactly. The SYNC discard is never counted.

Test Plan:
- Params FRAME_H=8, FRAME_V=8, TPL_H=4, TPL_V=4, STEP=2. Issue iStart, then a scorer model with 20-cycle windows. Required: oXstart/oYstart sequence after SYNC is (0,0),(2,0),(4,0),(0,2),…,(4,4); 9 captures; oDone pulses once; oBusy=0 afterwards.
- Same params, model returns score 100 everywhere except 500 at (4,2). Required: oBestX=4, oBestY=2, oBestScore=500.
- Model returns 300 at (2,0) and at (0,4), 10 elsewhere. Required: oBestX=2, oBestY=0 (the earlier position wins the tie).
- Model returns 0 at all positions. Required: oBestScore=0, oBestX=0, oBestY=0 (the first capture loads unconditionally).
- Pulse iStart at capture 4, then assert iRST for 1 cycle at capture 5. Required: the extra iStart has no effect on the sequence; after reset all outputs are 0, state is IDLE, and no oDone is produced. A fresh iStart then completes a full 9-position sweep.
- FRAME_H=TPL_H=4, FRAME_V=TPL_V=4. Required: exactly one capture at (0,0), then oDone.
